vga_scanout: RTL

Display-side consumer of the pixel frame buffer: generates 640x480@60 VGA timing, drives the frame buffer's `{row, column}` read address, and maps the returned 2-bit pixel codes to 24-bit RGB. Each stored pixel (320x240 buffer) is doubled horizontally and vertically. The block sits between the pixel memory's read port and the board VGA DAC. It only reads; write-port arbitration for the memory lives outside this block.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing.sv | 80 ++++++++
 rtl/vga_scanout.sv | 107 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared colour type, palette and default 640x480@60 timing for the VGA scanout path.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int lineTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = lineTotal(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = lineTotal(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // Element 0 is the rightmost entry: 00 black, 01 red, 10 green, 11 white.
    localparam rgb_t [3:0] PALETTE = {24'hFFFFFF, 24'h00FF00, 24'hFF0000, 24'h000000};

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider plus horizontal/vertical scan counters and the raw sync/blank flags they imply.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HW       = $clog2(lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_tick,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_hsync_raw,
    output logic          o_vsync_raw,
    output logic          o_blank_raw,
    output logic          o_active,
    output logic          o_frame_wrap
);

    localparam int H_TOTAL = lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = $clog2(CLK_DIV);

    logic [DW-1:0] r_div_cnt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_tick;
    logic          w_h_last;
    logic          w_v_last;

    assign w_tick   = (r_div_cnt == DW'(CLK_DIV - 1));
    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // The line counter advances on the same tick that wraps the pixel counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    assign o_tick       = w_tick;
    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_hsync_raw  = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                            (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync_raw  = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                            (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_blank_raw  = (r_h_cnt >= HW'(H_ACTIVE)) || (r_v_cnt >= VW'(V_ACTIVE));
    assign o_active     = !o_blank_raw;
    assign o_frame_wrap = w_tick && w_h_last && w_v_last;

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scanout: drives the pixel-doubled read address and registers sync, blank and palette colour.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int N        = 32,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   pix_data,
    output logic [N-1:0] mem_addr,
    output logic         hsync,
    output logic         vsync,
    output logic         blank,
    output logic [7:0]   vga_r,
    output logic [7:0]   vga_g,
    output logic [7:0]   vga_b,
    output logic         frame_start
);

    localparam int H_TOTAL = lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HALF    = N / 2;

    logic          w_tick;
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_hsync_raw;
    logic          w_vsync_raw;
    logic          w_blank_raw;
    logic          w_active;
    logic          w_frame_wrap;
    logic [HALF-1:0] w_row;
    logic [HALF-1:0] w_col;

    logic r_hsync;
    logic r_vsync;
    logic r_blank;
    rgb_t r_rgb;
    logic r_frame_start;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .o_tick      (w_tick),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_hsync_raw (w_hsync_raw),
        .o_vsync_raw (w_vsync_raw),
        .o_blank_raw (w_blank_raw),
        .o_active    (w_active),
        .o_frame_wrap(w_frame_wrap)
    );

    // Halving both counters shows each stored pixel as a 2x2 block.
    assign w_row    = HALF'(w_v_cnt >> 1);
    assign w_col    = HALF'(w_h_cnt >> 1);
    assign mem_addr = w_active ? {w_row, w_col} : '0;

    // Memory data for the current address lands one pixel later, so sync and blank share this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b1;
            r_rgb   <= '0;
        end else if (w_tick) begin
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_blank <= w_blank_raw;
            r_rgb   <= w_blank_raw ? '0 : PALETTE[pix_data];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_wrap;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign vga_r       = r_rgb.r;
    assign vga_g       = r_rgb.g;
    assign vga_b       = r_rgb.b;
    assign frame_start = r_frame_start;

endmodule
